param_exec_datapath: RTL and testbench
======================================

Name: param_exec_datapath

Overview:
Parametrised successor to the single-bus CPU datapath. It holds a NUM_REGS x WIDTH register file, HI/LO, PC, and in/out ports. It executes one register-transfer command at a time, accepted over a valid/ready handshake:
- single-cycle ALU ops
- iterative multi-cycle MUL/DIV into HI/LO
- loads/stores over a req/ack memory handshake

It sits between the control unit, which issues commands, and the RAM.

Parameters:
WIDTH, 32, datapath and register width (must be a power of two, at least 8)
NUM_REGS, 16, number of general registers (power of two); RSEL_W = $clog2(NUM_REGS)
ADDR_W, 9, memory address width; mem_addr = low ADDR_W bits of effective address

Ports:
clock  in  1  single clock; all state changes on its rising edge
clear  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  block idle; command accepted on a clock edge where cmd_valid & cmd_ready
cmd_op  in  4  opcode (see Behaviour)
cmd_ra, cmd_rb, cmd_rc  in  RSEL_W  register selects
cmd_imm  in  WIDTH  immediate, already sign-extended upstream
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  1 = store, 0 = load; valid while mem_req
mem_addr  out  ADDR_W  memory address
mem_wdata  out  WIDTH  store data
mem_ack  in  1  memory done; mem_rdata valid same cycle for loads
mem_rdata  in  WIDTH  load data
in_port_data  in  WIDTH  input port, sampled at accept
out_port_data  out  WIDTH  output port register
pc  out  WIDTH  program counter
done  out  1  one-cycle pulse: command retired, results visible
div_zero  out  1  sticky; set by DIV with divisor 0; cleared only by reset

Behaviour:
- Reset (clear=0, asynchronous):
  - all registers, HI, LO, PC and out_port_data go to 0
  - FSM goes to IDLE, mem_req=0, done=0, div_zero=0
  - mem_req drops immediately, with no wait for a clock edge
  - any in-flight op is abandoned with no writeback
- Operands ra/rb/imm/in_port_data are latched at accept, so a destination equal to a source is safe.
- Opcodes:
  - 0 ADD rc=ra+rb; 1 SUB rc=ra-rb; 2 AND; 3 OR (AND/OR write rc)
  - 4 SHL rc=ra<<rb[log2(WIDTH)-1:0]; 5 SHR logical, same shift-amount rule
  - 6 ADDI ra=rb+imm
  - 7 MUL {HI,LO}=ra*rb, unsigned, 2*WIDTH-bit product
  - 8 DIV LO=ra/rb, HI=ra%rb, unsigned
  - 9 MFHI ra=HI; 10 MFLO ra=LO
  - 11 LD ra=mem[rb+imm]; 12 ST mem[rb+imm]=ra
  - 13 IN ra=in_port_data; 14 OUT out_port_data=ra
  - 15 INCPC pc=pc+1
- Arithmetic wraps modulo 2^WIDTH; carries and overflow are discarded. PC wraps from all-ones to 0.
- FSM states: IDLE, EXEC, MULDIV, MEM.
  - cmd_ready = (state==IDLE).
  - cmd_valid is ignored while not ready.
- IDLE -> EXEC on accept of ops 0-6, 9, 10, 13, 14, 15.
  - EXEC writes the result and pulses done, then returns to IDLE.
  - Latency: done in the cycle after the accept edge; back-to-back accept every 2 cycles.
- IDLE -> MULDIV on ops 7/8.
  - MUL uses shift-add; DIV uses restoring division; one bit per cycle for WIDTH cycles.
  - HI/LO are written and done pulses on the edge after the last iteration: done appears WIDTH+1 cycles after accept.
  - HI/LO hold their old values until that final writeback.
- DIV with rb=0: no iteration. Result LO=all ones, HI=ra, div_zero set, done after 1 cycle.
- IDLE -> MEM on ops 11/12.
  - mem_req rises in the cycle after accept, with mem_addr/mem_we/mem_wdata stable until ack.
  - On an edge with mem_ack=1: LD writes ra from mem_rdata, mem_req deasserts next cycle, done pulses, state returns to IDLE.
  - There is no timeout; mem_ack outside MEM is ignored.
- Register writes happen only at the retirement edge; no partial results are visible.

Optional Feature:
R0_ZERO_EN
- Defined:
  - Register 0 reads as 0 everywhere, which gives base-address-zero semantics for LD/ST (rb=0 means an absolute imm address).
  - Writes to register 0 are discarded, though done still pulses.
- Undefined: register 0 is an ordinary register.

Test Plan:
- Reset, then ADDI r1=r0+5 and ADDI r2=r0+7, then ADD r3=r1+r2 -> done 1 cycle after each accept; r3=12; cmd_ready low only during EXEC.
- With r1=0xFFFF_FFFF and r2=2, issue MUL -> done exactly 33 cycles after accept; HI=1, LO=0xFFFF_FFFE. MFHI r4 -> r4=1.
- DIV r1=100, r2=7 -> LO=14, HI=2. DIV by r2=0 -> LO=0xFFFF_FFFF, HI=r1, div_zero=1 and stays set.
- ST r1 to [r0+0x10], with mem_ack delayed 3 cycles -> mem_req held 3 cycles, mem_addr=0x010, mem_we=1. Then LD r5 with mem_rdata=0xA5A5 -> r5=0xA5A5.
- Assert clear mid-MUL (iteration 10) and mid-MEM -> mem_req drops asynchronously; HI/LO/regs=0; cmd_ready=1 after release; no done pulse.
- INCPC from pc=0xFFFF_FFFF -> pc=0. With R0_ZERO_EN, ADDI r0=r0+9 then ADD r6=r0+r0 -> r6=0 (without the macro: r6=18).

Source files
------------

// File: rtl/param_exec_datapath.sv
// param_exec_datapath: register-transfer execution datapath with a register file, HI/LO, PC and
// I/O ports. It accepts one command at a time over a valid/ready handshake and runs it as a
// single-cycle ALU op, an iterative MUL/DIV, or a load/store over a req/ack memory handshake.
// Optional build macro R0_ZERO_EN: register 0 reads as zero and ignores writes.
module param_exec_datapath #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned ADDR_W   = 9
) (
    input  logic                        clock,
    input  logic                        clear,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [3:0]                  cmd_op,
    input  logic [$clog2(NUM_REGS)-1:0] cmd_ra,
    input  logic [$clog2(NUM_REGS)-1:0] cmd_rb,
    input  logic [$clog2(NUM_REGS)-1:0] cmd_rc,
    input  logic [WIDTH-1:0]            cmd_imm,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [WIDTH-1:0]            mem_wdata,
    input  logic                        mem_ack,
    input  logic [WIDTH-1:0]            mem_rdata,
    input  logic [WIDTH-1:0]            in_port_data,
    output logic [WIDTH-1:0]            out_port_data,
    output logic [WIDTH-1:0]            pc,
    output logic                        done,
    output logic                        div_zero
);

    localparam int unsigned RSEL_W = $clog2(NUM_REGS);
    localparam int unsigned SHW    = $clog2(WIDTH);
    localparam int unsigned CNT_W  = SHW + 1;
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH);

    localparam logic [3:0] OpAdd   = 4'd0;
    localparam logic [3:0] OpSub   = 4'd1;
    localparam logic [3:0] OpAnd   = 4'd2;
    localparam logic [3:0] OpOr    = 4'd3;
    localparam logic [3:0] OpShl   = 4'd4;
    localparam logic [3:0] OpShr   = 4'd5;
    localparam logic [3:0] OpAddi  = 4'd6;
    localparam logic [3:0] OpMul   = 4'd7;
    localparam logic [3:0] OpDiv   = 4'd8;
    localparam logic [3:0] OpMfhi  = 4'd9;
    localparam logic [3:0] OpMflo  = 4'd10;
    localparam logic [3:0] OpLd    = 4'd11;
    localparam logic [3:0] OpSt    = 4'd12;
    localparam logic [3:0] OpIn    = 4'd13;
    localparam logic [3:0] OpOut   = 4'd14;
    localparam logic [3:0] OpIncpc = 4'd15;

    typedef enum logic [1:0] {StIdle, StExec, StMulDiv, StMem} state_t;

    state_t r_state, w_state_next;

    logic                w_accept;
    logic                w_div_by_zero;
    logic                w_md_last;
    logic                w_retire;
    logic                w_rf_we;
    logic [WIDTH-1:0]    w_rf_wdata;
    logic [WIDTH-1:0]    w_ra_val;
    logic [WIDTH-1:0]    w_rb_val;
    logic [WIDTH-1:0]    w_alu;
    logic [2*WIDTH-1:0]  w_md_step;
    logic [WIDTH:0]      w_mul_sum;
    logic [WIDTH:0]      w_div_rs;
    logic [WIDTH:0]      w_div_tr;

    logic [3:0]          r_op;
    logic [RSEL_W-1:0]   r_dst;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [WIDTH-1:0]    r_imm;
    logic [WIDTH-1:0]    r_in;
    logic [WIDTH-1:0]    r_ea;
    logic [WIDTH-1:0]    r_hi;
    logic [WIDTH-1:0]    r_lo;
    logic [WIDTH-1:0]    r_pc;
    logic [WIDTH-1:0]    r_out;
    logic [2*WIDTH-1:0]  r_p;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_done;
    logic                r_div_zero;
    logic                r_mem_req;
    logic [WIDTH-1:0]    r_regs [NUM_REGS];

    assign cmd_ready     = (r_state == StIdle);
    assign done          = r_done;
    assign div_zero      = r_div_zero;
    assign pc            = r_pc;
    assign out_port_data = r_out;
    assign mem_req       = r_mem_req;
    assign mem_we        = (r_op == OpSt);
    assign mem_wdata     = r_a;

    // Memory address is the low ADDR_W bits of the effective address (zero-extended if wider).
    if (ADDR_W < WIDTH) begin : g_addr_trunc
        logic w_unused_ea;
        assign mem_addr    = r_ea[ADDR_W-1:0];
        assign w_unused_ea = ^r_ea[WIDTH-1:ADDR_W];
    end else if (ADDR_W == WIDTH) begin : g_addr_same
        assign mem_addr = r_ea;
    end else begin : g_addr_ext
        assign mem_addr = {{(ADDR_W-WIDTH){1'b0}}, r_ea};
    end

    // Register file read ports for operand capture at accept.
    always_comb begin
        w_ra_val = r_regs[cmd_ra];
        w_rb_val = r_regs[cmd_rb];
`ifdef R0_ZERO_EN
        if (cmd_ra == '0) w_ra_val = '0;
        if (cmd_rb == '0) w_rb_val = '0;
`endif
    end

    assign w_div_by_zero = (r_op == OpDiv) && (r_b == '0);
    assign w_md_last     = (r_cnt == CntLast) || w_div_by_zero;

    // Next-state logic; a command is only taken while idle.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_retire     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (cmd_valid) begin
                    w_accept = 1'b1;
                    case (cmd_op)
                        OpMul, OpDiv: w_state_next = StMulDiv;
                        OpLd, OpSt:   w_state_next = StMem;
                        default:      w_state_next = StExec;
                    endcase
                end
            end
            StExec: begin
                w_retire     = 1'b1;
                w_state_next = StIdle;
            end
            StMulDiv: begin
                if (w_md_last) begin
                    w_retire     = 1'b1;
                    w_state_next = StIdle;
                end
            end
            StMem: begin
                if (mem_ack) begin
                    w_retire     = 1'b1;
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) r_state <= StIdle;
        else        r_state <= w_state_next;
    end

    // Single-cycle ALU result from the latched operands.
    always_comb begin
        w_alu = '0;
        case (r_op)
            OpAdd:   w_alu = r_a + r_b;
            OpSub:   w_alu = r_a - r_b;
            OpAnd:   w_alu = r_a & r_b;
            OpOr:    w_alu = r_a | r_b;
            OpShl:   w_alu = r_a << r_b[SHW-1:0];
            OpShr:   w_alu = r_a >> r_b[SHW-1:0];
            OpAddi:  w_alu = r_b + r_imm;
            OpMfhi:  w_alu = r_hi;
            OpMflo:  w_alu = r_lo;
            OpIn:    w_alu = r_in;
            default: w_alu = '0;
        endcase
    end

    // One MUL (shift-add) or DIV (restoring) iteration on the {hi,lo} work register.
    always_comb begin
        w_mul_sum = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_a} : '0);
        w_div_rs  = {r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1]};
        w_div_tr  = w_div_rs - {1'b0, r_b};
        if (r_op == OpMul) begin
            w_md_step = {w_mul_sum, r_p[WIDTH-1:1]};
        end else if (w_div_tr[WIDTH]) begin
            w_md_step = {w_div_rs[WIDTH-1:0], r_p[WIDTH-2:0], 1'b0};
        end else begin
            w_md_step = {w_div_tr[WIDTH-1:0], r_p[WIDTH-2:0], 1'b1};
        end
    end

    // Register file write port: only at the retirement edge.
    always_comb begin
        w_rf_we    = 1'b0;
        w_rf_wdata = w_alu;
        if (r_state == StExec) begin
            w_rf_we = (r_op <= OpAddi) || (r_op == OpMfhi) || (r_op == OpMflo) || (r_op == OpIn);
        end else if ((r_state == StMem) && mem_ack && (r_op == OpLd)) begin
            w_rf_we    = 1'b1;
            w_rf_wdata = mem_rdata;
        end
`ifdef R0_ZERO_EN
        if (r_dst == '0) w_rf_we = 1'b0;
`endif
    end

    // Register file storage.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (w_rf_we) begin
            r_regs[r_dst] <= w_rf_wdata;
        end
    end

    // Operand capture at accept so a destination may alias a source.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_op  <= '0;
            r_dst <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_imm <= '0;
            r_in  <= '0;
            r_ea  <= '0;
        end else if (w_accept) begin
            r_op  <= cmd_op;
            r_dst <= (cmd_op <= OpShr) ? cmd_rc : cmd_ra;
            r_a   <= w_ra_val;
            r_b   <= w_rb_val;
            r_imm <= cmd_imm;
            r_in  <= in_port_data;
            r_ea  <= w_rb_val + cmd_imm;
        end
    end

    // MUL/DIV iteration: WIDTH steps, then HI/LO writeback on the following edge.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_p        <= '0;
            r_cnt      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_div_zero <= 1'b0;
        end else if (w_accept) begin
            r_p   <= {{WIDTH{1'b0}}, (cmd_op == OpMul) ? w_rb_val : w_ra_val};
            r_cnt <= '0;
        end else if (r_state == StMulDiv) begin
            if (w_div_by_zero) begin
                r_lo       <= '1;
                r_hi       <= r_a;
                r_div_zero <= 1'b1;
            end else if (r_cnt == CntLast) begin
                r_hi <= r_p[2*WIDTH-1:WIDTH];
                r_lo <= r_p[WIDTH-1:0];
            end else begin
                r_p   <= w_md_step;
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // PC, output port, memory request and retirement pulse.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_pc      <= '0;
            r_out     <= '0;
            r_mem_req <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_retire;
            if (w_accept) begin
                r_mem_req <= (cmd_op == OpLd) || (cmd_op == OpSt);
            end else if ((r_state == StMem) && mem_ack) begin
                r_mem_req <= 1'b0;
            end
            if (r_state == StExec) begin
                if (r_op == OpOut)   r_out <= r_a;
                if (r_op == OpIncpc) r_pc  <= r_pc + WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_param_exec_datapath.sv
// Directed bench for param_exec_datapath: a 32-bit instance for the main behaviour and a small
// 8-bit instance to reach the PC wrap point quickly.
module tb_param_exec_datapath;

    logic clock = 1'b0;
    logic clear = 1'b0;
    always #5 clock = ~clock;

    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = '0;
    logic [3:0]  cmd_ra = '0, cmd_rb = '0, cmd_rc = '0;
    logic [31:0] cmd_imm = '0;
    logic        mem_req, mem_we;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] in_port_data = '0;
    logic [31:0] out_port_data, pc;
    logic        done, div_zero;

    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [3:0]  s_op = 4'd15;
    logic [1:0]  s_ra = '0, s_rb = '0, s_rc = '0;
    logic [7:0]  s_imm = '0;
    logic        s_mem_req, s_mem_we;
    logic [3:0]  s_mem_addr;
    logic [7:0]  s_mem_wdata;
    logic [7:0]  s_mem_rdata = '0;
    logic        s_mem_ack = 1'b0;
    logic [7:0]  s_in = '0;
    logic [7:0]  s_out, s_pc;
    logic        s_done, s_div_zero;

    int n_tests = 0;
    int n_fail  = 0;

    param_exec_datapath #(.WIDTH(32), .NUM_REGS(16), .ADDR_W(9)) dut (
        .clock(clock), .clear(clear), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rc(cmd_rc), .cmd_imm(cmd_imm),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .in_port_data(in_port_data),
        .out_port_data(out_port_data), .pc(pc), .done(done), .div_zero(div_zero)
    );

    param_exec_datapath #(.WIDTH(8), .NUM_REGS(4), .ADDR_W(4)) dut_small (
        .clock(clock), .clear(clear), .cmd_valid(s_valid), .cmd_ready(s_ready),
        .cmd_op(s_op), .cmd_ra(s_ra), .cmd_rb(s_rb), .cmd_rc(s_rc), .cmd_imm(s_imm),
        .mem_req(s_mem_req), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
        .mem_ack(s_mem_ack), .mem_rdata(s_mem_rdata), .in_port_data(s_in),
        .out_port_data(s_out), .pc(s_pc), .done(s_done), .div_zero(s_div_zero)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Issue one command and wait (bounded) for done; lat = cycles from accept edge to done.
    task automatic issue(input logic [3:0] op, input logic [3:0] ra, input logic [3:0] rb,
                         input logic [3:0] rc, input logic [31:0] imm,
                         output int lat, output logic busy_rdy);
        cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_rc = rc; cmd_imm = imm;
        cmd_valid = 1'b1;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        busy_rdy = cmd_ready;
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clock); #1;
            lat++;
        end
        if (lat >= 100) begin
            n_tests++; n_fail++;
            $display("FAIL timeout_op%0d: no done after %0d cycles, required done", op, lat);
        end
    endtask

    task automatic read_reg(input logic [3:0] r, output logic [31:0] v);
        int l; logic b;
        issue(4'd14, r, 4'd0, 4'd0, 32'h0, l, b);
        v = out_port_data;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        clear = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", cmd_ready); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b required 0", done); end
        n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b required 0", mem_req); end
        n_tests++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h required 0", pc); end
        n_tests++; if (out_port_data !== 32'h0) begin n_fail++; $display("FAIL reset_out: got %h required 0", out_port_data); end
        n_tests++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL reset_div_zero: got %b required 0", div_zero); end
        #2 clear = 1'b1;
        @(posedge clock); #1;
        n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after: got %b required 1", cmd_ready); end
        read_reg(4'd3, v);
        n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL reset_r3: got %h required 0", v); end
    endtask

    task automatic test_alu();
        int l; logic b; logic [31:0] v;
        issue(4'd6, 4'd1, 4'd0, 4'd0, 32'd5, l, b);
        n_tests++; if (l !== 1) begin n_fail++; $display("FAIL addi_latency: got %0d required 1", l); end
        n_tests++; if (b !== 1'b0) begin n_fail++; $display("FAIL exec_ready_low: got %b required 0", b); end
        n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_done: got %b required 1", cmd_ready); end
        issue(4'd6, 4'd2, 4'd0, 4'd0, 32'd7, l, b);
        issue(4'd0, 4'd1, 4'd2, 4'd3, 32'd0, l, b);
        n_tests++; if (l !== 1) begin n_fail++; $display("FAIL add_latency: got %0d required 1", l); end
        read_reg(4'd3, v);
        n_tests++; if (v !== 32'd12) begin n_fail++; $display("FAIL add_r3: got %h required %h", v, 32'd12); end
        issue(4'd1, 4'd1, 4'd2, 4'd4, 32'd0, l, b);
        read_reg(4'd4, v);
        n_tests++; if (v !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL sub_wrap: got %h required FFFFFFFE", v); end
        issue(4'd2, 4'd1, 4'd2, 4'd5, 32'd0, l, b);
        read_reg(4'd5, v);
        n_tests++; if (v !== 32'd5) begin n_fail++; $display("FAIL and: got %h required 5", v); end
        issue(4'd3, 4'd1, 4'd2, 4'd6, 32'd0, l, b);
        read_reg(4'd6, v);
        n_tests++; if (v !== 32'd7) begin n_fail++; $display("FAIL or: got %h required 7", v); end
        issue(4'd4, 4'd2, 4'd1, 4'd8, 32'd0, l, b);
        read_reg(4'd8, v);
        n_tests++; if (v !== 32'h0000_00E0) begin n_fail++; $display("FAIL shl: got %h required E0", v); end
        issue(4'd5, 4'd4, 4'd1, 4'd9, 32'd0, l, b);
        read_reg(4'd9, v);
        n_tests++; if (v !== 32'h07FF_FFFF) begin n_fail++; $display("FAIL shr_logical: got %h required 07FFFFFF", v); end
        issue(4'd6, 4'd7, 4'd0, 4'd0, 32'd33, l, b);
        issue(4'd4, 4'd2, 4'd7, 4'd10, 32'd0, l, b);
        read_reg(4'd10, v);
        n_tests++; if (v !== 32'd14) begin n_fail++; $display("FAIL shl_amount_low_bits: got %h required E", v); end
        in_port_data = 32'hDEAD_BEEF;
        issue(4'd13, 4'd11, 4'd0, 4'd0, 32'd0, l, b);
        in_port_data = 32'h0;
        read_reg(4'd11, v);
        n_tests++; if (v !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL in_port: got %h required DEADBEEF", v); end
        issue(4'd0, 4'd1, 4'd1, 4'd1, 32'd0, l, b);
        read_reg(4'd1, v);
        n_tests++; if (v !== 32'd10) begin n_fail++; $display("FAIL add_alias: got %h required A", v); end
        issue(4'd6, 4'd2, 4'd2, 4'd0, 32'd1, l, b);
        read_reg(4'd2, v);
        n_tests++; if (v !== 32'd8) begin n_fail++; $display("FAIL addi_alias: got %h required 8", v); end
    endtask

    task automatic test_muldiv();
        int l; logic b; logic [31:0] v;
        issue(4'd6, 4'd1, 4'd0, 4'd0, 32'hFFFF_FFFF, l, b);
        issue(4'd6, 4'd2, 4'd0, 4'd0, 32'd2, l, b);
        issue(4'd7, 4'd1, 4'd2, 4'd0, 32'd0, l, b);
        n_tests++; if (l !== 33) begin n_fail++; $display("FAIL mul_latency: got %0d required 33", l); end
        issue(4'd9, 4'd4, 4'd0, 4'd0, 32'd0, l, b);
        read_reg(4'd4, v);
        n_tests++; if (v !== 32'd1) begin n_fail++; $display("FAIL mul_hi: got %h required 1", v); end
        issue(4'd10, 4'd5, 4'd0, 4'd0, 32'd0, l, b);
        read_reg(4'd5, v);
        n_tests++; if (v !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mul_lo: got %h required FFFFFFFE", v); end
        issue(4'd6, 4'd1, 4'd0, 4'd0, 32'd100, l, b);
        issue(4'd6, 4'd2, 4'd0, 4'd0, 32'd7, l, b);
        issue(4'd8, 4'd1, 4'd2, 4'd0, 32'd0, l, b);
        n_tests++; if (l !== 33) begin n_fail++; $display("FAIL div_latency: got %0d required 33", l); end
        issue(4'd10, 4'd4, 4'd0, 4'd0, 32'd0, l, b);
        read_reg(4'd4, v);
        n_tests++; if (v !== 32'd14) begin n_fail++; $display("FAIL div_quot: got %h required E", v); end
        issue(4'd9, 4'd5, 4'd0, 4'd0, 32'd0, l, b);
        read_reg(4'd5, v);
        n_tests++; if (v !== 32'd2) begin n_fail++; $display("FAIL div_rem: got %h required 2", v); end
        n_tests++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL div_zero_clear: got %b required 0", div_zero); end
        issue(4'd6, 4'd2, 4'd0, 4'd0, 32'd0, l, b);
        issue(4'd8, 4'd1, 4'd2, 4'd0, 32'd0, l, b);
        n_tests++; if (l !== 1) begin n_fail++; $display("FAIL div0_latency: got %0d required 1", l); end
        n_tests++; if (div_zero !== 1'b1) begin n_fail++; $display("FAIL div0_flag: got %b required 1", div_zero); end
        issue(4'd10, 4'd4, 4'd0, 4'd0, 32'd0, l, b);
        read_reg(4'd4, v);
        n_tests++; if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div0_lo: got %h required FFFFFFFF", v); end
        issue(4'd9, 4'd5, 4'd0, 4'd0, 32'd0, l, b);
        read_reg(4'd5, v);
        n_tests++; if (v !== 32'd100) begin n_fail++; $display("FAIL div0_hi: got %h required 64", v); end
        n_tests++; if (div_zero !== 1'b1) begin n_fail++; $display("FAIL div0_sticky: got %b required 1", div_zero); end
    endtask

    task automatic test_mem();
        int l; logic b; logic [31:0] v; int held;
        mem_ack = 1'b1;
        @(posedge clock); #1;
        mem_ack = 1'b0;
        n_tests++; if (done !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL ack_idle_ignored: got done=%b ready=%b required 0/1", done, cmd_ready); end
        issue(4'd6, 4'd1, 4'd0, 4'd0, 32'h1234_5678, l, b);
        cmd_op = 4'd12; cmd_ra = 4'd1; cmd_rb = 4'd0; cmd_imm = 32'h10; cmd_valid = 1'b1;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        n_tests++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL st_we: got %b required 1", mem_we); end
        n_tests++; if (mem_addr !== 9'h010) begin n_fail++; $display("FAIL st_addr: got %h required 010", mem_addr); end
        n_tests++; if (mem_wdata !== 32'h1234_5678) begin n_fail++; $display("FAIL st_wdata: got %h required 12345678", mem_wdata); end
        held = 0;
        for (int i = 0; i < 3; i++) begin
            if (mem_req === 1'b1 && done === 1'b0) held++;
            @(posedge clock); #1;
        end
        n_tests++; if (held !== 3) begin n_fail++; $display("FAIL st_req_held: got %0d cycles required 3", held); end
        mem_ack = 1'b1;
        @(posedge clock); #1;
        mem_ack = 1'b0;
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL st_done: got %b required 1", done); end
        n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL st_req_drop: got %b required 0", mem_req); end
        cmd_op = 4'd11; cmd_ra = 4'd5; cmd_rb = 4'd1; cmd_imm = 32'h10; cmd_valid = 1'b1;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        n_tests++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin n_fail++; $display("FAIL ld_req: got req=%b we=%b required 1/0", mem_req, mem_we); end
        n_tests++; if (mem_addr !== 9'h088) begin n_fail++; $display("FAIL ld_addr_trunc: got %h required 088", mem_addr); end
        mem_ack = 1'b1; mem_rdata = 32'h0000_A5A5;
        @(posedge clock); #1;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL ld_done: got %b required 1", done); end
        read_reg(4'd5, v);
        n_tests++; if (v !== 32'h0000_A5A5) begin n_fail++; $display("FAIL ld_data: got %h required A5A5", v); end
    endtask

    task automatic test_pc_wrap();
        int cnt; int cyc;
        cnt = 0; cyc = 0;
        s_valid = 1'b1;
        while (cnt < 255 && cyc < 2000) begin
            @(posedge clock); #1;
            cyc++;
            if (s_done === 1'b1) cnt++;
        end
        s_valid = 1'b0;
        n_tests++; if (s_pc !== 8'hFF) begin n_fail++; $display("FAIL pc_all_ones: got %h required FF", s_pc); end
        s_valid = 1'b1;
        @(posedge clock); #1;
        s_valid = 1'b0;
        @(posedge clock); #1;
        n_tests++; if (s_done !== 1'b1 || s_pc !== 8'h00) begin n_fail++; $display("FAIL pc_wrap: got done=%b pc=%h required 1/00", s_done, s_pc); end
    endtask

    task automatic test_r0();
        int l; logic b; logic [31:0] v; logic [31:0] exp_r6;
`ifdef R0_ZERO_EN
        exp_r6 = 32'd0;
`else
        exp_r6 = 32'd18;
`endif
        issue(4'd6, 4'd0, 4'd0, 4'd0, 32'd9, l, b);
        n_tests++; if (l !== 1) begin n_fail++; $display("FAIL r0_write_done: got %0d required 1", l); end
        issue(4'd0, 4'd0, 4'd0, 4'd6, 32'd0, l, b);
        read_reg(4'd6, v);
        n_tests++; if (v !== exp_r6) begin n_fail++; $display("FAIL r0_semantics: got %h required %h", v, exp_r6); end
    endtask

    task automatic test_reset_midop();
        int l; logic b; logic [31:0] v; int seen;
        issue(4'd6, 4'd1, 4'd0, 4'd0, 32'd3, l, b);
        issue(4'd6, 4'd2, 4'd0, 4'd0, 32'd5, l, b);
        cmd_op = 4'd7; cmd_ra = 4'd1; cmd_rb = 4'd2; cmd_valid = 1'b1;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        repeat (10) @(posedge clock);
        #3 clear = 1'b0;
        #1;
        n_tests++; if (cmd_ready !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL mul_abort: got ready=%b done=%b required 1/0", cmd_ready, done); end
        @(posedge clock); #3 clear = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (done === 1'b1) seen++;
        end
        n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL mul_abort_no_done: got %0d pulses required 0", seen); end
        issue(4'd10, 4'd7, 4'd0, 4'd0, 32'd0, l, b);
        read_reg(4'd7, v);
        n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL mul_abort_lo: got %h required 0", v); end
        read_reg(4'd1, v);
        n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL mul_abort_r1: got %h required 0", v); end
        issue(4'd6, 4'd1, 4'd0, 4'd0, 32'h55, l, b);
        cmd_op = 4'd12; cmd_ra = 4'd1; cmd_rb = 4'd0; cmd_imm = 32'h4; cmd_valid = 1'b1;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        n_tests++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL mem_abort_pre: got %b required 1", mem_req); end
        #2 clear = 1'b0;
        #1;
        n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL mem_req_async_drop: got %b required 0", mem_req); end
        @(posedge clock); #3 clear = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            if (done === 1'b1 || mem_req === 1'b1) seen++;
        end
        n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL mem_abort_quiet: got %0d active cycles required 0", seen); end
        n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL mem_abort_ready: got %b required 1", cmd_ready); end
        n_tests++; if (out_port_data !== 32'h0 || pc !== 32'h0 || div_zero !== 1'b0) begin n_fail++; $display("FAIL mem_abort_state: got out=%h pc=%h dz=%b required 0/0/0", out_port_data, pc, div_zero); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_muldiv();
        test_mem();
        test_pc_wrap();
        test_r0();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
